// File: rtl/uart_rx.sv
// ---------------------------------------------------------------------------
// uart_rx -- oversampling UART receiver.
//
// Receives LSB-first asynchronous frames (start bit, DATA_BITS data bits,
// optional even-parity bit, one stop bit) from an idle-high serial line.
// Sampling is paced by an external oversample strobe `tick` running at
// Baud * OVERSAMPLING; each bit is sampled once at its middle.
//
// Optional feature macro: UART_RX_PARITY_EN
//   defined   -> frames carry one even-parity bit after the data and
//                parity_error reports mismatches.
//   undefined -> no parity bit is expected and parity_error is tied to 0.
//
// Parameters
//   OVERSAMPLING : tick pulses per bit period (even, 4..64)
//   DATA_BITS    : data bits per frame (5..8)
//
// Ports
//   clk          in   single clock, rising edge
//   reset        in   synchronous, active-high reset
//   tick         in   one-clk oversample strobe
//   rxd          in   asynchronous serial line, idle high
//   data_out     out  last received data word (held between frames)
//   data_valid   out  one-clk pulse: good frame in data_out
//   frame_error  out  one-clk pulse: stop bit sampled low
//   parity_error out  one-clk pulse alongside data_valid/frame_error when
//                     the parity check failed
//   busy         out  high whenever the receiver is not idle
//
// Handshake: data_valid and frame_error are single-cycle, mutually
// exclusive strobes with no back-pressure; data_out is valid in the cycle
// either strobe is high and keeps that value until the next frame ends.
// ---------------------------------------------------------------------------
module uart_rx #(
    parameter int OVERSAMPLING = 16,
    parameter int DATA_BITS    = 8
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 tick,
    input  logic                 rxd,
    output logic [DATA_BITS-1:0] data_out,
    output logic                 data_valid,
    output logic                 frame_error,
    output logic                 parity_error,
    output logic                 busy
);

    localparam int CW = $clog2(OVERSAMPLING);
    localparam int BW = $clog2(DATA_BITS);

    localparam logic [CW-1:0] HALF_LAST = CW'(OVERSAMPLING / 2 - 1);
    localparam logic [CW-1:0] FULL_LAST = CW'(OVERSAMPLING - 1);
    localparam logic [BW-1:0] LAST_BIT  = BW'(DATA_BITS - 1);

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_START  = 3'd1,
        S_DATA   = 3'd2,
`ifdef UART_RX_PARITY_EN
        S_PARITY = 3'd3,
`endif
        S_STOP   = 3'd4,
        S_BREAK  = 3'd5
    } state_t;

    state_t               state;
    state_t               state_next;

    logic                 rx_meta;
    logic                 rxs;
    logic [CW-1:0]        cnt;
    logic [BW-1:0]        bit_idx;
    logic [DATA_BITS-1:0] shreg;

    // half_hit marks the middle of the start bit (counted from the falling
    // edge); mid_hit marks the middle of every later bit because the
    // counter restarts at the start-bit midpoint.
    logic                 half_hit;
    logic                 mid_hit;

    assign half_hit = tick && (cnt == HALF_LAST);
    assign mid_hit  = tick && (cnt == FULL_LAST);
    assign busy     = (state != S_IDLE);

    // -----------------------------------------------------------------------
    // State register
    // -----------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (reset) begin
            state <= S_IDLE;
        end else begin
            state <= state_next;
        end
    end

    // -----------------------------------------------------------------------
    // Next-state logic
    // -----------------------------------------------------------------------
    always_comb begin
        state_next = state;
        case (state)
            S_IDLE: begin
                if (!rxs) state_next = S_START;
            end
            S_START: begin
                // A line that is high again at mid-start was a glitch.
                if (half_hit) state_next = rxs ? S_IDLE : S_DATA;
            end
            S_DATA: begin
                if (mid_hit && (bit_idx == LAST_BIT)) begin
`ifdef UART_RX_PARITY_EN
                    state_next = S_PARITY;
`else
                    state_next = S_STOP;
`endif
                end
            end
`ifdef UART_RX_PARITY_EN
            S_PARITY: begin
                if (mid_hit) state_next = S_STOP;
            end
`endif
            S_STOP: begin
                // Returning to IDLE at mid-stop lets a start bit that follows
                // immediately be caught without an idle gap.
                if (mid_hit) state_next = rxs ? S_IDLE : S_BREAK;
            end
            S_BREAK: begin
                if (rxs) state_next = S_IDLE;
            end
            default: state_next = S_IDLE;
        endcase
    end

    // -----------------------------------------------------------------------
    // Synchronizer, counters, shift register and output strobes
    // -----------------------------------------------------------------------
`ifdef UART_RX_PARITY_EN
    logic parity_bad;
    logic parity_err_q;
    assign parity_error = parity_err_q;
`else
    assign parity_error = 1'b0;
`endif

    always_ff @(posedge clk) begin
        if (reset) begin
            rx_meta      <= 1'b1;
            rxs          <= 1'b1;
            cnt          <= '0;
            bit_idx      <= '0;
            shreg        <= '0;
            data_out     <= '0;
            data_valid   <= 1'b0;
            frame_error  <= 1'b0;
`ifdef UART_RX_PARITY_EN
            parity_bad   <= 1'b0;
            parity_err_q <= 1'b0;
`endif
        end else begin
            rx_meta     <= rxd;
            rxs         <= rx_meta;
            data_valid  <= 1'b0;
            frame_error <= 1'b0;
`ifdef UART_RX_PARITY_EN
            parity_err_q <= 1'b0;
`endif

            // Counter restarts on every state change and is parked at zero
            // in the states that do not time anything.
            if ((state_next != state) || (state == S_IDLE) || (state == S_BREAK)) begin
                cnt <= '0;
            end else if (tick) begin
                cnt <= (cnt == FULL_LAST) ? '0 : cnt + CW'(1);
            end

            if (state != S_DATA) begin
                bit_idx <= '0;
            end else if (mid_hit) begin
                bit_idx <= bit_idx + BW'(1);
            end

            // LSB arrives first, so shift in from the top.
            if ((state == S_DATA) && mid_hit) begin
                shreg <= {rxs, shreg[DATA_BITS-1:1]};
            end

`ifdef UART_RX_PARITY_EN
            if (state == S_START) begin
                parity_bad <= 1'b0;
            end else if ((state == S_PARITY) && mid_hit) begin
                // Even parity: data bits plus parity bit must XOR to zero.
                parity_bad <= (^shreg) ^ rxs;
            end
`endif

            if ((state == S_STOP) && mid_hit) begin
                data_out <= shreg;
                if (rxs) begin
                    data_valid <= 1'b1;
                end else begin
                    frame_error <= 1'b1;
                end
`ifdef UART_RX_PARITY_EN
                parity_err_q <= parity_bad;
`endif
            end
        end
    end

endmodule
